// File: rtl/lcdi_weight_mac_pkg.sv
// Shared constants, state encodings and index helpers for the LCDI weight MAC.
// Used by lcdi_weight_mac and lcdi_coef_rom; the coefficient write port is enabled by LCDI_COEF_WR_EN.
package lcdi_weight_mac_pkg;

    localparam int LCDI_DATA_WIDTH   = 8;
    localparam int LCDI_NUM_CLASSES  = 81;
    localparam int LCDI_IDX_WIDTH    = 7;
    localparam int LCDI_NUM_TAPS     = 4;
    localparam int LCDI_COEF_DEFAULT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef logic [LCDI_IDX_WIDTH-1:0] lcdi_idx_t;

    // Class indices above the last ROM entry carry no weight and flag an error.
    function automatic logic lcdi_idx_illegal(input lcdi_idx_t idx);
        return (idx > LCDI_IDX_WIDTH'(LCDI_NUM_CLASSES - 1));
    endfunction

endpackage

// File: rtl/lcdi_weight_mac_coef_rom.sv
// 81-entry coefficient store with a registered (1-cycle) read.
// With LCDI_COEF_WR_EN defined the store is writable; otherwise every entry is the fixed default.
module lcdi_coef_rom
    import lcdi_weight_mac_pkg::*;
#(
    parameter int COEF_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  lcdi_idx_t             rd_addr,
`ifdef LCDI_COEF_WR_EN
    input  logic                  wr_en,
    input  lcdi_idx_t             wr_addr,
    input  logic [COEF_WIDTH-1:0] wr_data,
`endif
    output logic [COEF_WIDTH-1:0] rd_data
);

    logic [COEF_WIDTH-1:0] rd_data_r;

`ifdef LCDI_COEF_WR_EN
    logic [COEF_WIDTH-1:0] mem_r [LCDI_NUM_CLASSES];

    // Coefficient storage; reset restores the averaging weights.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LCDI_NUM_CLASSES; i++) begin
                mem_r[i] <= COEF_WIDTH'(LCDI_COEF_DEFAULT);
            end
        end else if (wr_en && !lcdi_idx_illegal(wr_addr)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= {COEF_WIDTH{1'b0}};
        end else if (rd_en && !lcdi_idx_illegal(rd_addr)) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end
`else
    // Registered read port over a constant table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= {COEF_WIDTH{1'b0}};
        end else if (rd_en && !lcdi_idx_illegal(rd_addr)) begin
            rd_data_r <= COEF_WIDTH'(LCDI_COEF_DEFAULT);
        end
    end
`endif

    assign rd_data = rd_data_r;

endmodule

// File: rtl/lcdi_weight_mac.sv
// Four-tap weight multiply-accumulate: class index -> ROM weight, sum of weight*pixel, round/normalise/saturate.
// Optional runtime coefficient writes are enabled by defining LCDI_COEF_WR_EN.
module lcdi_weight_mac
    import lcdi_weight_mac_pkg::*;
#(
    parameter int DATA_WIDTH = LCDI_DATA_WIDTH,
    parameter int COEF_WIDTH = 8,
    parameter int NORM_SHIFT = 8,
    parameter int ACC_WIDTH  = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LCDI_IDX_WIDTH-1:0] index0,
    input  logic [LCDI_IDX_WIDTH-1:0] index1,
    input  logic [LCDI_IDX_WIDTH-1:0] index2,
    input  logic [LCDI_IDX_WIDTH-1:0] index3,
    input  logic [DATA_WIDTH-1:0]     pix0,
    input  logic [DATA_WIDTH-1:0]     pix1,
    input  logic [DATA_WIDTH-1:0]     pix2,
    input  logic [DATA_WIDTH-1:0]     pix3,
`ifdef LCDI_COEF_WR_EN
    input  logic                      coef_we,
    input  logic [LCDI_IDX_WIDTH-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]     coef_wdata,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_pix,
    output logic                      out_err
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam logic [ACC_WIDTH:0] ROUND_BIAS = (ACC_WIDTH + 1)'(1) << (NORM_SHIFT - 1);

    logic [1:0]            state_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  out_err_r;
    logic [DATA_WIDTH-1:0] out_pix_r;
    logic                  err_r;
    logic [ACC_WIDTH-1:0]  acc_r;
    logic [1:0]            k_r;
    logic                  mac_vld_r;
    logic [1:0]            mac_k_r;
    logic                  mac_oor_r;
    lcdi_idx_t             idx_r [LCDI_NUM_TAPS];
    logic [DATA_WIDTH-1:0] pix_r [LCDI_NUM_TAPS];

    logic                  accept_s;
    lcdi_idx_t             rom_addr_s;
    logic                  tap_oor_s;
    logic                  rom_rd_s;
    logic [COEF_WIDTH-1:0] rom_data_s;
    logic [COEF_WIDTH-1:0] weight_s;
    logic [PROD_WIDTH-1:0] prod_s;
    logic [ACC_WIDTH-1:0]  acc_next_s;
    logic [ACC_WIDTH:0]    round_s;
    logic [ACC_WIDTH:0]    norm_s;
    logic [DATA_WIDTH-1:0] sat_s;

    assign accept_s = in_valid && in_ready_r;

    // Address issue for tap k; illegal indices skip the ROM entirely.
    always_comb begin
        rom_addr_s = idx_r[k_r];
        tap_oor_s  = lcdi_idx_illegal(rom_addr_s);
        rom_rd_s   = (state_r == ST_FETCH) && !tap_oor_s;
    end

    // Product of the weight returned this cycle with its paired pixel, then round and saturate.
    always_comb begin
        if (mac_oor_r) begin
            weight_s = {COEF_WIDTH{1'b0}};
        end else begin
            weight_s = rom_data_s;
        end
        prod_s     = PROD_WIDTH'(weight_s) * PROD_WIDTH'(pix_r[mac_k_r]);
        acc_next_s = acc_r + ACC_WIDTH'(prod_s);
        round_s    = {1'b0, acc_r} + ROUND_BIAS;
        norm_s     = round_s >> NORM_SHIFT;
        if (|norm_s[ACC_WIDTH:DATA_WIDTH]) begin
            sat_s = {DATA_WIDTH{1'b1}};
        end else begin
            sat_s = norm_s[DATA_WIDTH-1:0];
        end
    end

`ifdef LCDI_COEF_WR_EN
    logic coef_wr_s;
    assign coef_wr_s = coef_we && (state_r == ST_IDLE) && !lcdi_idx_illegal(coef_addr);
`endif

    lcdi_coef_rom #(
        .COEF_WIDTH (COEF_WIDTH)
    ) u_coef_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rom_rd_s),
        .rd_addr (rom_addr_s),
`ifdef LCDI_COEF_WR_EN
        .wr_en   (coef_wr_s),
        .wr_addr (coef_addr),
        .wr_data (coef_wdata),
`endif
        .rd_data (rom_data_s)
    );

    // Capture the index/pixel set on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LCDI_NUM_TAPS; i++) begin
                idx_r[i] <= {LCDI_IDX_WIDTH{1'b0}};
                pix_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            idx_r[0] <= index0;
            idx_r[1] <= index1;
            idx_r[2] <= index2;
            idx_r[3] <= index3;
            pix_r[0] <= pix0;
            pix_r[1] <= pix1;
            pix_r[2] <= pix2;
            pix_r[3] <= pix3;
        end
    end

    // Tags that follow each ROM read so the product lines up with the returned weight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_vld_r <= 1'b0;
            mac_k_r   <= 2'd0;
            mac_oor_r <= 1'b0;
        end else begin
            mac_vld_r <= (state_r == ST_FETCH);
            mac_k_r   <= k_r;
            mac_oor_r <= tap_oor_s;
        end
    end

    // Control FSM, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_pix_r   <= {DATA_WIDTH{1'b0}};
            out_err_r   <= 1'b0;
            err_r       <= 1'b0;
            acc_r       <= {ACC_WIDTH{1'b0}};
            k_r         <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r      <= {ACC_WIDTH{1'b0}};
                        err_r      <= lcdi_idx_illegal(index0) || lcdi_idx_illegal(index1) ||
                                      lcdi_idx_illegal(index2) || lcdi_idx_illegal(index3);
                        k_r        <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_FETCH;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    k_r <= k_r + 2'd1;
                    if (mac_vld_r) begin
                        acc_r <= acc_next_s;
                    end
                    if (k_r == 2'd3) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mac_vld_r) begin
                        acc_r <= acc_next_s;
                    end else begin
                        out_pix_r   <= sat_s;
                        out_err_r   <= err_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pix   = out_pix_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_lcdi_weight_mac.sv
// Directed self-checking bench for lcdi_weight_mac; coefficient-write cases build when LCDI_COEF_WR_EN is defined.
module tb_lcdi_weight_mac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] index0 = 7'd0, index1 = 7'd0, index2 = 7'd0, index3 = 7'd0;
    logic [7:0] pix0 = 8'd0, pix1 = 8'd0, pix2 = 8'd0, pix3 = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_pix;
    logic       out_err;
`ifdef LCDI_COEF_WR_EN
    logic       coef_we = 1'b0;
    logic [6:0] coef_addr = 7'd0;
    logic [7:0] coef_wdata = 8'd0;
`endif

    int checks = 0;
    int errors = 0;

    lcdi_weight_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .index0     (index0),
        .index1     (index1),
        .index2     (index2),
        .index3     (index3),
        .pix0       (pix0),
        .pix1       (pix1),
        .pix2       (pix2),
        .pix3       (pix3),
`ifdef LCDI_COEF_WR_EN
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pix    (out_pix),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_set(input logic [6:0] i0, input logic [6:0] i1,
                              input logic [6:0] i2, input logic [6:0] i3,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_val("in_ready_before_accept", int'(in_ready), 1);
        index0 = i0; index1 = i1; index2 = i2; index3 = i3;
        pix0 = p0; pix1 = p1; pix2 = p2; pix3 = p3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef LCDI_COEF_WR_EN
        coef_we = 1'b0;
`endif
        check_val("in_ready_after_accept", int'(in_ready), 0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 30);
    endtask

    task automatic run_expect(input string tag,
                              input logic [6:0] i0, input logic [6:0] i1,
                              input logic [6:0] i2, input logic [6:0] i3,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input int exp_pix, input int exp_err);
        int lat;
        accept_set(i0, i1, i2, i3, p0, p1, p2, p3);
        wait_result(lat);
        check_val({tag, "_latency"}, lat, 6);
        check_val({tag, "_pix"}, int'(out_pix), exp_pix);
        check_val({tag, "_err"}, int'(out_err), exp_err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, int'(out_valid), 0);
        check_val({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

`ifdef LCDI_COEF_WR_EN
    task automatic write_coef(input logic [6:0] addr, input logic [7:0] data);
        coef_we = 1'b1;
        coef_addr = addr;
        coef_wdata = data;
        tick();
        coef_we = 1'b0;
    endtask
`endif

    initial begin
        int lat;

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        check_val("rst_in_ready", int'(in_ready), 0);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_pix", int'(out_pix), 0);
        check_val("rst_out_err", int'(out_err), 0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_in_ready", int'(in_ready), 1);

        // Averaging and rounding: out = (64*sum + 128) >> 8
        run_expect("avg", 7'd0, 7'd40, 7'd80, 7'd12, 8'd10, 8'd20, 8'd30, 8'd41, 25, 0);
        run_expect("zero", 7'd1, 7'd2, 7'd3, 7'd4, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0);
        run_expect("full", 7'd7, 7'd7, 7'd7, 7'd7, 8'd255, 8'd255, 8'd255, 8'd255, 255, 0);
        run_expect("round_dn", 7'd1, 7'd1, 7'd1, 7'd1, 8'd1, 8'd1, 8'd1, 8'd2, 1, 0);
        run_expect("round_up", 7'd1, 7'd1, 7'd1, 7'd1, 8'd1, 8'd2, 8'd1, 8'd2, 2, 0);

        // Illegal index contributes nothing and flags only its own result
        run_expect("illegal", 7'd3, 7'd7, 7'd100, 7'd9, 8'd100, 8'd100, 8'd100, 8'd100, 75, 1);
        run_expect("after_illegal", 7'd0, 7'd0, 7'd0, 7'd0, 8'd100, 8'd100, 8'd100, 8'd100, 100, 0);
        run_expect("illegal_max", 7'd127, 7'd81, 7'd0, 7'd0, 8'd200, 8'd200, 8'd100, 8'd100, 50, 1);

        // Backpressure: result held, in_valid pulses ignored
        accept_set(7'd1, 7'd2, 7'd3, 7'd4, 8'd40, 8'd40, 8'd40, 8'd40);
        wait_result(lat);
        check_val("bp_latency", lat, 6);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            index0 = 7'd50;
            pix0 = 8'd200;
            tick();
            check_val("bp_valid", int'(out_valid), 1);
            check_val("bp_pix", int'(out_pix), 40);
            check_val("bp_err", int'(out_err), 0);
            check_val("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_release_valid", int'(out_valid), 0);
        check_val("bp_release_in_ready", int'(in_ready), 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_val("bp_no_extra_result", int'(out_valid), 0);
        end

        // Reset during FETCH abandons the transaction
        accept_set(7'd0, 7'd0, 7'd0, 7'd0, 8'd200, 8'd200, 8'd200, 8'd200);
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midrst_out_valid", int'(out_valid), 0);
        check_val("midrst_in_ready", int'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val("midrst_no_result", int'(out_valid), 0);
        end
        check_val("midrst_idle", int'(in_ready), 1);
        run_expect("after_midrst", 7'd0, 7'd40, 7'd80, 7'd12, 8'd10, 8'd20, 8'd30, 8'd41, 25, 0);

`ifdef LCDI_COEF_WR_EN
        // Coefficient writes
        write_coef(7'd5, 8'd128);
        run_expect("wr_128", 7'd5, 7'd5, 7'd5, 7'd5, 8'd50, 8'd50, 8'd50, 8'd50, 100, 0);
        write_coef(7'd0, 8'd255);
        write_coef(7'd1, 8'd255);
        write_coef(7'd2, 8'd255);
        write_coef(7'd3, 8'd255);
        run_expect("saturate", 7'd0, 7'd1, 7'd2, 7'd3, 8'd255, 8'd255, 8'd255, 8'd255, 255, 0);
        coef_we = 1'b1;
        coef_addr = 7'd6;
        coef_wdata = 8'd32;
        run_expect("wr_same_cycle", 7'd6, 7'd6, 7'd6, 7'd6, 8'd50, 8'd50, 8'd50, 8'd50, 25, 0);
        accept_set(7'd8, 7'd8, 7'd8, 7'd8, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_result(lat);
        check_val("busy_wr_latency", lat, 6);
        write_coef(7'd7, 8'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_expect("busy_wr_dropped", 7'd7, 7'd7, 7'd7, 7'd7, 8'd100, 8'd100, 8'd100, 8'd100, 100, 0);
        write_coef(7'd90, 8'd0);
        run_expect("oor_wr_dropped", 7'd9, 7'd9, 7'd9, 7'd9, 8'd100, 8'd100, 8'd100, 8'd100, 100, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
